// File: rtl/wb_mem_2_ppfifo_pkg.sv
// ============================================================================
//  Module      : dma_writer_defines (package)
//  Description : Shared definitions for the memory-to-ping-pong-FIFO DMA
//                engine: FSM state encoding, wishbone byte-select constant,
//                host status bit positions and the FIFO half picker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_writer_defines;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_REQ  = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // Bit positions of the per-buffer flags inside the host status register
    localparam int STS_FINISHED0 = 0;
    localparam int STS_FINISHED1 = 1;
    localparam int STS_EMPTY0    = 2;
    localparam int STS_EMPTY1    = 3;

    // Lowest ready half wins; caller guarantees rdy != 0
    function automatic logic [1:0] pick_half(input logic [1:0] rdy);
        return rdy[0] ? 2'b01 : 2'b10;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_mem2ppfifo_buf_desc.sv
// ============================================================================
//  Module      : wb_mem2ppfifo_buf_desc
//  Description : One memory buffer descriptor: base, size, words-read count,
//                finished and empty flags.
//  Ports       : clk, rst (async, active-low)
//                i_load/i_base/i_size  - latch a new buffer (pre-qualified)
//                i_inc                 - one word read from this buffer
//                i_done                - buffer complete: finished + empty
//                i_clear               - abandon buffer: empty only
//                o_base/o_size/o_count/o_finished/o_empty - descriptor state
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mem2ppfifo_buf_desc (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_base,
    input  logic [31:0] i_size,
    input  logic        i_inc,
    input  logic        i_done,
    input  logic        i_clear,
    output logic [31:0] o_base,
    output logic [31:0] o_size,
    output logic [31:0] o_count,
    output logic        o_finished,
    output logic        o_empty
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_base     <= 32'd0;
            o_size     <= 32'd0;
            o_count    <= 32'd0;
            o_finished <= 1'b0;
            o_empty    <= 1'b1;
        end else if (i_load) begin
            // A fresh descriptor overrides anything else in the same cycle
            o_base     <= i_base;
            o_size     <= i_size;
            o_count    <= 32'd0;
            o_finished <= 1'b0;
            o_empty    <= 1'b0;
        end else begin
            if (i_inc) begin
                o_count <= o_count + 32'd1;
            end
            if (i_done) begin
                o_finished <= 1'b1;
                o_empty    <= 1'b1;
            end else if (i_clear) begin
                o_empty <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_mem_2_ppfifo.sv
// ============================================================================
//  Module      : wb_mem_2_ppfifo
//  Description : Wishbone-master DMA engine reading words from two alternately
//                serviced memory buffers into the write side of a ping-pong
//                FIFO. One word per REQ/NEXT pair, FIFO half released at every
//                window end and every buffer end.
//  Ports       : clk, rst (async, active-low), i_enable, i_flush
//                i_memory_N_* / o_memory_N_*  - buffer N descriptor + status
//                o_error                      - sticky ack-timeout flag
//                o_mem_* / i_mem_*            - wishbone master (read only)
//                i_wr_rdy/o_wr_act/i_wr_size/o_wr_stb/o_wr_data - PPFIFO write
//  Options     : WB_MEM_2_PPFIFO_TIMEOUT_EN - abort a beat after TIMEOUT_CYCLES
//                without ack; otherwise o_error is 0 and ack is awaited forever
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mem_2_ppfifo
    import dma_writer_defines::*;
#(
    parameter int ADDR_INC       = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_flush,
    input  logic [31:0] i_memory_0_base,
    input  logic [31:0] i_memory_0_size,
    input  logic        i_memory_0_ready,
    output logic [31:0] o_memory_0_count,
    output logic        o_memory_0_finished,
    output logic        o_memory_0_empty,
    input  logic [31:0] i_memory_1_base,
    input  logic [31:0] i_memory_1_size,
    input  logic        i_memory_1_ready,
    output logic [31:0] o_memory_1_count,
    output logic        o_memory_1_finished,
    output logic        o_memory_1_empty,
    output logic        o_error,
    output logic        o_mem_we,
    output logic        o_mem_stb,
    output logic        o_mem_cyc,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic [31:0] i_mem_dat,
    input  logic        i_mem_ack,
    input  logic        i_mem_int,
    input  logic [1:0]  i_wr_rdy,
    output logic [1:0]  o_wr_act,
    input  logic [23:0] i_wr_size,
    output logic        o_wr_stb,
    output logic [31:0] o_wr_data
);

    state_t      r_state;
    logic        r_cur;          // buffer being serviced
    logic        r_pref;         // buffer to try first on the next pick
    logic        r_flush_pend;
    logic [23:0] r_win;          // words written in the current FIFO window

    logic [31:0] w_base  [2];
    logic [31:0] w_size  [2];
    logic [31:0] w_count [2];
    logic [1:0]  w_fin, w_empty;
    logic [1:0]  w_load, w_inc, w_done, w_clear;
    logic [31:0] w_cur_base, w_cur_size, w_cur_count, w_addr;
    logic        w_sel, w_flush_now, w_timeout;
    logic [3:0]  w_status;
    logic        w_unused;

    assign o_mem_we  = 1'b0;
    assign o_mem_sel = WB_SEL_ALL;
    assign o_mem_dat = 32'd0;

    assign w_flush_now = r_flush_pend | i_flush;

    always_comb begin
        w_load      = 2'b00;
        w_inc       = 2'b00;
        w_done      = 2'b00;
        w_clear     = 2'b00;
        // The buffer being serviced may not be reloaded under the engine
        w_load[0]   = i_memory_0_ready && (i_memory_0_size != 32'd0)
                      && !((r_state != ST_IDLE) && (r_cur == 1'b0));
        w_load[1]   = i_memory_1_ready && (i_memory_1_size != 32'd0)
                      && !((r_state != ST_IDLE) && (r_cur == 1'b1));
        w_cur_base  = r_cur ? w_base[1]  : w_base[0];
        w_cur_size  = r_cur ? w_size[1]  : w_size[0];
        w_cur_count = r_cur ? w_count[1] : w_count[0];
        w_addr      = w_cur_base + (w_cur_count * 32'(ADDR_INC));
        w_sel       = w_empty[r_pref] ? ~r_pref : r_pref;
        if ((r_state == ST_REQ) && i_mem_ack) begin
            w_inc[r_cur] = 1'b1;
        end
        if ((r_state == ST_NEXT) && (w_cur_count == w_cur_size)) begin
            w_done[r_cur] = 1'b1;
        end
        // Flush is only acted on once no beat is outstanding
        if ((r_state == ST_IDLE) && w_flush_now) begin
            w_clear = 2'b11;
        end
        if (w_timeout) begin
            w_clear[r_cur] = 1'b1;
        end
    end

    wb_mem2ppfifo_buf_desc u_buf0 (
        .clk(clk), .rst(rst), .i_load(w_load[0]),
        .i_base(i_memory_0_base), .i_size(i_memory_0_size),
        .i_inc(w_inc[0]), .i_done(w_done[0]), .i_clear(w_clear[0]),
        .o_base(w_base[0]), .o_size(w_size[0]), .o_count(w_count[0]),
        .o_finished(w_fin[0]), .o_empty(w_empty[0])
    );

    wb_mem2ppfifo_buf_desc u_buf1 (
        .clk(clk), .rst(rst), .i_load(w_load[1]),
        .i_base(i_memory_1_base), .i_size(i_memory_1_size),
        .i_inc(w_inc[1]), .i_done(w_done[1]), .i_clear(w_clear[1]),
        .o_base(w_base[1]), .o_size(w_size[1]), .o_count(w_count[1]),
        .o_finished(w_fin[1]), .o_empty(w_empty[1])
    );

    // Status flags gathered in host register layout
    always_comb begin
        w_status                = 4'd0;
        w_status[STS_FINISHED0] = w_fin[0];
        w_status[STS_FINISHED1] = w_fin[1];
        w_status[STS_EMPTY0]    = w_empty[0];
        w_status[STS_EMPTY1]    = w_empty[1];
    end

    assign o_memory_0_count    = w_count[0];
    assign o_memory_1_count    = w_count[1];
    assign o_memory_0_finished = w_status[STS_FINISHED0];
    assign o_memory_1_finished = w_status[STS_FINISHED1];
    assign o_memory_0_empty    = w_status[STS_EMPTY0];
    assign o_memory_1_empty    = w_status[STS_EMPTY1];

`ifdef WB_MEM_2_PPFIFO_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_error;

    assign w_timeout = (r_state == ST_REQ) && !i_mem_ack
                       && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign o_error   = r_error;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= 32'd0;
            r_error  <= 1'b0;
        end else begin
            if (o_mem_stb && !i_mem_ack) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end else begin
                r_to_cnt <= 32'd0;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign w_unused = &{1'b0, i_mem_int};
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
    assign w_unused  = &{1'b0, i_mem_int, 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cur        <= 1'b0;
            r_pref       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_win        <= 24'd0;
            o_wr_act     <= 2'b00;
            o_mem_cyc    <= 1'b0;
            o_mem_stb    <= 1'b0;
            o_mem_adr    <= 32'd0;
            o_wr_stb     <= 1'b0;
            o_wr_data    <= 32'd0;
        end else begin
            o_wr_stb <= 1'b0;
            if (i_flush) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_flush_now) begin
                        r_flush_pend <= 1'b0;
                    end else if (i_enable && (w_empty != 2'b11)) begin
                        r_cur   <= w_sel;
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_flush_now || !i_enable) begin
                        r_state <= ST_IDLE;
                    end else if (i_wr_rdy != 2'b00) begin
                        o_wr_act  <= pick_half(i_wr_rdy);
                        r_win     <= 24'd0;
                        o_mem_cyc <= 1'b1;
                        o_mem_stb <= 1'b1;
                        o_mem_adr <= w_addr;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_mem_ack) begin
                        o_wr_data <= i_mem_dat;
                        o_wr_stb  <= 1'b1;
                        o_mem_cyc <= 1'b0;
                        o_mem_stb <= 1'b0;
                        r_win     <= r_win + 24'd1;
                        r_state   <= ST_NEXT;
                    end else if (w_timeout) begin
                        o_mem_cyc <= 1'b0;
                        o_mem_stb <= 1'b0;
                        o_wr_act  <= 2'b00;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_NEXT: begin
                    if (w_cur_count == w_cur_size) begin
                        o_wr_act <= 2'b00;
                        r_pref   <= ~r_cur;
                        r_state  <= ST_IDLE;
                    end else if (r_win == i_wr_size) begin
                        o_wr_act <= 2'b00;
                        r_state  <= ST_ARM;
                    end else if (!i_enable || w_flush_now) begin
                        o_wr_act <= 2'b00;
                        r_state  <= ST_IDLE;
                    end else begin
                        o_mem_cyc <= 1'b1;
                        o_mem_stb <= 1'b1;
                        o_mem_adr <= w_addr;
                        r_state   <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/wb_mem_2_ppfifo.md
Name: wb_mem_2_ppfifo

Overview:
- Wishbone-master DMA engine that reads words from memory and pushes them into the write side of a ping-pong FIFO.
- It is the memory-to-FIFO counterpart of the FIFO-to-memory writer used by the DMA reader slave, and is intended for a DMA writer slave core.
- Two memory buffer descriptors (base, size) are serviced alternately.
- Progress is reported per buffer through count, finished and empty outputs, which the host slave exposes as status registers.

Parameters:
- ADDR_INC, 1: address increment per word (word addressing).
- TIMEOUT_CYCLES, 255: ack timeout limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_enable  in  1  run enable
- i_flush  in  1  abort pulse; discards both pending buffers
- i_memory_0_base  in  32  buffer 0 start word address
- i_memory_0_size  in  32  buffer 0 length in words
- i_memory_0_ready  in  1  one-cycle pulse that loads buffer 0
- o_memory_0_count  out  32  words read from buffer 0
- o_memory_0_finished  out  1  buffer 0 fully read
- o_memory_0_empty  out  1  no pending buffer 0 work
- i_memory_1_*, o_memory_1_*  same set of ports for buffer 1
- o_error  out  1  sticky ack-timeout flag
- o_mem_we, o_mem_stb, o_mem_cyc  out  1 each  wishbone master controls
- o_mem_sel  out  4  byte select
- o_mem_adr  out  32  address
- o_mem_dat  out  32  write data
- i_mem_dat  in  32  read data
- i_mem_ack  in  1  ack
- i_mem_int  in  1  ignored
- i_wr_rdy  in  2  FIFO halves ready
- o_wr_act  out  2  FIFO half activate
- i_wr_size  in  24  FIFO half capacity
- o_wr_stb  out  1  FIFO write strobe
- o_wr_data  out  32  FIFO write data

Behaviour:
- Reset (rst low, asynchronous) clears all outputs to 0 except o_memory_0_empty and o_memory_1_empty, which reset to 1. State returns to IDLE. o_mem_cyc drops immediately.
- Fixed outputs: o_mem_we=0, o_mem_sel=4'hF, o_mem_dat=0.
- Load: a ready pulse with size>0 on an idle buffer latches base and size, clears count and finished, and clears empty.
  - A ready pulse with size=0 is ignored.
  - A ready pulse on the active buffer is ignored.
- Buffer selection: buffers are serviced alternately starting with buffer 0. If the preferred buffer is empty and the other is loaded, the other is taken.
- IDLE:
  - i_enable=1 and a loaded buffer present -> ARM.
- ARM:
  - Waits for i_wr_rdy!=0, then drives o_wr_act to the lowest ready bit (bit 0 wins on tie).
  - Clears the window word counter, then -> REQ.
- REQ:
  - Asserts o_mem_cyc and o_mem_stb with o_mem_adr = base + count*ADDR_INC.
  - On the cycle i_mem_ack is sampled high, registers i_mem_dat into o_wr_data, pulses o_wr_stb for exactly one cycle, and drops o_mem_stb and o_mem_cyc.
  - Increments count and the window counter, then -> NEXT.
- NEXT, evaluated in this priority order:
  - count==size: set finished and empty, drop o_wr_act -> IDLE.
  - Window counter==i_wr_size: drop o_wr_act -> ARM.
  - i_enable=0 or flush pending: drop o_wr_act -> IDLE.
  - Otherwise -> REQ.
- Throughput: at most one word per 2 cycles plus ack latency.
- Activate: o_wr_act is never held across a buffer boundary. The FIFO half is released at each buffer end, which may leave a partial packet.
- i_enable deasserted mid-transfer: any outstanding beat completes. Count is retained and the buffer stays loaded, so it resumes at the same address when re-enabled.
- i_flush: latched as pending. After any outstanding ack, the window is released and both buffers go empty=1. Finished is not set and counts are retained.
- Simultaneous finish of buffer N and a ready pulse for the other buffer: both take effect.
- o_memory_N_finished stays high until the next valid ready pulse for that buffer.

Optional Feature:
- Macro: WB_MEM_2_PPFIFO_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while stb is high. Reaching TIMEOUT_CYCLES without ack drops cyc and stb and sets o_error (sticky until reset).
  - The active buffer is marked empty, not finished, o_wr_act is released, and state -> IDLE.
- Without the macro: no counter, o_error is tied 0, and the engine waits indefinitely for ack.

Decomposition:
- Shared package (dma_writer_defines):
  - state encodings IDLE/ARM/REQ/NEXT;
  - the WB_SEL_ALL constant;
  - status bit positions (finished0, finished1, empty0, empty1) shared with the host slave.
- Sub-module wb_mem2ppfifo_buf_desc, instantiated twice: holds base, size, count, finished and empty, with load, increment and abort inputs.

Test Plan:
- Load buffer 0 with base 0x100, size 4; i_wr_size=8, ack one cycle after stb:
  - reads addresses 0x100–0x103 in order;
  - 4 o_wr_stb pulses with matching data;
  - finished0=1, count0=4, o_wr_act released.
- Buffer 0 size 3 and buffer 1 base 0x200 size 2 loaded back-to-back:
  - buffer 0 fully read before buffer 1;
  - two separate activate windows;
  - both finished flags set.
- Size 10, i_wr_size=4, i_wr_rdy toggling 2'b01 then 2'b10:
  - windows of 4, 4 and 2 words on alternating halves;
  - count0=10.
- Flush pulse after 2 of 6 words, with ack stalled 5 cycles:
  - beat completes and o_wr_stb fires;
  - activate dropped, empty0=empty1=1, finished0=0, count0=3.
- rst pulled low during REQ:
  - o_mem_cyc=0 within the same cycle, before the next clk edge;
  - all counts 0, empty flags 1.
- With the timeout macro defined and TIMEOUT_CYCLES=16, ack never returned:
  - cyc drops after 16 cycles;
  - o_error=1, state IDLE.
